mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-stage load/store unit for the RV32I pipeline, between the EX/MEM pipeline register and the MEM/WB register. It turns ALU results and store operands into aligned transactions on a single-port req/ack data-memory bus, and sign- or zero-extends load data. It presents wb_data/rd/register-write-enable to MEM/WB and stalls the pipeline while a memory access is outstanding. Misaligned, illegal and timed-out accesses are flagged, and their register write is suppressed.

## Interface
- TIMEOUT, 16: cycles a request may wait for mem_ack before it is aborted (2..255).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- valid_in  in  1  EX/MEM holds a live instruction.
- alu_result_in  in  32  byte address for memory ops, result for non-memory ops.
- store_data_in  in  32  rs2 value for stores.
- instruction_rd_in  in  5  destination register.
- register_write_enable_in  in  1  instruction writes rd.
- mem_read_in  in  1  load.
- mem_write_in  in  1  store.
- funct3_in  in  3  access size/sign.
- mem_req  out  1  request, held until ack or abort.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, alu_result_in with bits [1:0] forced to 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 0 for reads.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe.
- wb_data_out  out  32  to MEM/WB wb_data_in.
- instruction_rd_out  out  5  to MEM/WB.
- register_write_enable_out  out  1  to MEM/WB.
- mem_fault  out  1  one-cycle pulse for a misaligned, illegal or timed-out access.
- stall  out  1  1 = hold EX/MEM and earlier stages, and deassert MEM/WB en.

## Operation
- FSM states: IDLE, REQ, RESP.
- Access = valid_in & (mem_read_in | mem_write_in).
- Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Legal stores: SB 000, SH 001, SW 010.
- Fault conditions:
  - Any other funct3.
  - mem_read_in & mem_write_in both set.
  - Misalignment: halfword with addr[0]=1, or word with addr[1:0]≠0.
- IDLE, no access: pass-through. wb_data_out=alu_result_in, rd passes, register_write_enable_out = register_write_enable_in & valid_in, stall=0.
- IDLE, faulting access: mem_fault=1 and register_write_enable_out=0 in the same cycle. No bus activity, stall=0, stay in IDLE.
- IDLE, legal access: stall=1. Register mem_addr/mem_we/mem_wdata/mem_wstrb, set mem_req, clear the timeout counter, go to REQ.
- REQ: stall=1 and bus outputs held stable.
  - mem_ack=1: capture the extended load data, go to RESP.
  - mem_ack=0: increment the counter. When counter reaches TIMEOUT-1, drop mem_req, set the abort flag, go to RESP.
- RESP: stall=0, mem_req=0, always return to IDLE.
  - Load: wb_data_out = captured data, register_write_enable_out = register_write_enable_in.
  - Store: register_write_enable_out=0.
  - Abort: mem_fault=1 and register_write_enable_out=0.
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wstrb=0011<<addr[1:0].
  - SW: wdata=sd, wstrb=1111.
- Load extract: lane = mem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend lane[7:0]/lane[15:0].
  - LBU/LHU zero-extend.
  - LW uses mem_rdata unchanged.
- mem_ack outside REQ is ignored.
- mem_ack in the same cycle as timeout expiry: ack wins, no fault.
- Upstream holds all *_in stable while stall=1.

## Timing
- Reset (rst=0 at posedge) forces:
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - Captured data=0, counter=0, abort flag=0.
- Reset mid-REQ drops mem_req next edge. The bus abandons the transaction, and a late ack is ignored.
- Pass-through and fault paths are combinational: zero cycles, no stall.
- Legal access with ack in the first REQ cycle: stall for 2 cycles (IDLE, REQ). Result is valid in RESP and captured by MEM/WB at the end of RESP.
- Ack after n REQ cycles: n+1 stall cycles.
- Timeout: TIMEOUT+1 stall cycles, then RESP with mem_fault.
- Back-to-back accesses: each takes at least 3 cycles (IDLE, REQ, RESP). The next instruction is evaluated in IDLE on the cycle after RESP.

## Test plan
- LB, addr 0x1003, ack 0 wait, mem_rdata 0x80FFFFFF -> wb_data_out 0xFFFFFF80, rd/we passed, stall high for exactly 2 cycles.
- LHU addr 0x2002, mem_rdata 0xBEEF1234 -> wb_data_out 0x0000BEEF. LW addr 0x2001 -> mem_fault pulse, no mem_req, register_write_enable_out 0, stall 0.
- SB addr 0x11, sd 0x123456AB -> mem_addr 0x10, wdata 0xABABABAB, wstrb 0010, mem_we 1. SH addr 0x12 -> wstrb 1100. RESP write enable 0.
- ALU op (mem_read=mem_write=0), alu_result 0xDEADBEEF, rd 7, we 1 -> same-cycle pass-through, stall 0, no mem_req.
- TIMEOUT=16, no ack -> mem_req high 16 cycles, then RESP with mem_fault=1 and register_write_enable_out 0. Repeat with ack on the 16th cycle -> no fault, data returned.
- rst=0 during REQ -> mem_req 0 next edge, all outputs at reset values. A subsequent stray mem_ack does not change state.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// RV32I memory-stage load/store unit: drives the req/ack data bus,
// aligns store lanes, extends load data and stalls while busy.
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  instruction_rd_in,
  input  logic        register_write_enable_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] wb_data_out,
  output logic [4:0]  instruction_rd_out,
  output logic        register_write_enable_out,
  output logic        mem_fault,
  output logic        stall
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nx;
  logic        abort_q;
  logic        abort_nx;
  logic [31:0] rdata_q;
  logic [31:0] rdata_nx;
  logic [1:0]  lo_q;
  logic [1:0]  lo_nx;
  logic [2:0]  f3_q;
  logic [2:0]  f3_nx;
  logic        ld_q;
  logic        ld_nx;

  logic        req_nx;
  logic        we_nx;
  logic [31:0] addr_nx;
  logic [31:0] wdata_nx;
  logic [3:0]  wstrb_nx;

  logic        access;
  logic        f3_ok;
  logic        misal;
  logic        bad;
  logic        legal;
  logic        sz_b;
  logic        sz_h;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;

  function automatic logic [31:0] extract(
    input logic [31:0] d,
    input logic [1:0]  lo,
    input logic [2:0]  f3
  );
    logic [31:0] ln;
    logic [31:0] r;
    ln = d >> {lo, 3'b000};
    unique case (f3)
      3'b000:  r = {{24{ln[7]}}, ln[7:0]};
      3'b001:  r = {{16{ln[15]}}, ln[15:0]};
      3'b100:  r = {24'h0, ln[7:0]};
      3'b101:  r = {16'h0, ln[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    access = valid_in & (mem_read_in | mem_write_in);
    if (mem_read_in)
      f3_ok = funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      f3_ok = funct3_in inside {3'b000, 3'b001, 3'b010};
    misal = ((funct3_in[1:0] == 2'b01) & alu_result_in[0])
          | ((funct3_in[1:0] == 2'b10) & (|alu_result_in[1:0]));
    bad   = access & ((mem_read_in & mem_write_in) | ~f3_ok | misal);
    legal = access & ~bad;
  end

  always_comb begin
    sz_b       = funct3_in[1:0] == 2'b00;
    sz_h       = funct3_in[1:0] == 2'b01;
    lane_wdata = store_data_in;
    lane_wstrb = 4'b1111;
    unique case (1'b1)
      sz_b: begin
        lane_wdata = {4{store_data_in[7:0]}};
        lane_wstrb = 4'b0001 << alu_result_in[1:0];
      end
      sz_h: begin
        lane_wdata = {2{store_data_in[15:0]}};
        lane_wstrb = 4'b0011 << alu_result_in[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    abort_nx  = abort_q;
    rdata_nx  = rdata_q;
    lo_nx     = lo_q;
    f3_nx     = f3_q;
    ld_nx     = ld_q;
    req_nx    = mem_req;
    we_nx     = mem_we;
    addr_nx   = mem_addr;
    wdata_nx  = mem_wdata;
    wstrb_nx  = mem_wstrb;
    stall     = 1'b0;
    mem_fault = 1'b0;
    wb_data_out               = alu_result_in;
    instruction_rd_out        = instruction_rd_in;
    register_write_enable_out = register_write_enable_in & valid_in;

    unique case (state)
      IDLE: begin
        if (bad) begin
          mem_fault                 = 1'b1;
          register_write_enable_out = 1'b0;
        end else if (legal) begin
          stall    = 1'b1;
          register_write_enable_out = 1'b0;
          req_nx   = 1'b1;
          we_nx    = mem_write_in;
          addr_nx  = {alu_result_in[31:2], 2'b00};
          wdata_nx = mem_write_in ? lane_wdata : 32'h0;
          wstrb_nx = mem_write_in ? lane_wstrb : 4'h0;
          cnt_nx   = 8'h0;
          abort_nx = 1'b0;
          lo_nx    = alu_result_in[1:0];
          f3_nx    = funct3_in;
          ld_nx    = mem_read_in;
          state_nx = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        register_write_enable_out = 1'b0;
        // ack in the expiry cycle still completes the access
        if (mem_ack) begin
          rdata_nx = extract(mem_rdata, lo_q, f3_q);
          req_nx   = 1'b0;
          state_nx = RESP;
        end else if (cnt == CNT_LAST) begin
          req_nx   = 1'b0;
          abort_nx = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt + 8'h1;
        end
      end
      RESP: begin
        if (abort_q) begin
          mem_fault                 = 1'b1;
          register_write_enable_out = 1'b0;
        end else if (ld_q) begin
          wb_data_out               = rdata_q;
          register_write_enable_out = register_write_enable_in;
        end else begin
          register_write_enable_out = 1'b0;
        end
        abort_nx = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'h0;
      abort_q   <= 1'b0;
      rdata_q   <= 32'h0;
      lo_q      <= 2'b00;
      f3_q      <= 3'b000;
      ld_q      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      abort_q   <= abort_nx;
      rdata_q   <= rdata_nx;
      lo_q      <= lo_nx;
      f3_q      <= f3_nx;
      ld_q      <= ld_nx;
      mem_req   <= req_nx;
      mem_we    <= we_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      mem_wstrb <= wstrb_nx;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed plan steps plus random accesses
// checked against a byte-level model of the load/store rules.
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  instruction_rd_in;
  logic        register_write_enable_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] wb_data_out;
  logic [4:0]  instruction_rd_out;
  logic        register_write_enable_out;
  logic        mem_fault;
  logic        stall;

  int errors = 0;
  int checks = 0;

  logic [31:0] last_wb;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;
  logic        last_we;
  logic        last_resp_fault;
  int          last_req_hi;
  int          last_stalls;

  mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .alu_result_in(alu_result_in),
    .store_data_in(store_data_in),
    .instruction_rd_in(instruction_rd_in),
    .register_write_enable_in(register_write_enable_in),
    .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in),
    .funct3_in(funct3_in),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .wb_data_out(wb_data_out),
    .instruction_rd_out(instruction_rd_out),
    .register_write_enable_out(register_write_enable_out),
    .mem_fault(mem_fault),
    .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_fault(input bit r, input bit w,
                                 input logic [2:0] f3,
                                 input logic [31:0] a);
    if (r && w) return 1'b1;
    if (r && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (w && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
    return (int'(a[1:0]) % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3,
                                         input logic [31:0] a);
    int n;
    n = m_bytes(f3);
    return 4'(((1 << n) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] sd);
    logic [31:0] w;
    int n;
    n = m_bytes(f3);
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] d);
    logic [31:0] v;
    logic [31:0] mask;
    int n;
    n = m_bytes(f3);
    if (n == 4) return d;
    v    = d >> (8 * int'(a[1:0]));
    mask = (32'h1 << (8 * n)) - 32'h1;
    v    = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_inputs();
    valid_in     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    mem_ack      = 1'b0;
  endtask

  // ack_at: index of the REQ cycle carrying mem_ack, -1 for none
  task automatic mem_op(input bit rd_i, input bit wr_i,
                        input logic [2:0] f3,
                        input logic [31:0] addr,
                        input logic [31:0] sd,
                        input logic [4:0] rdx,
                        input bit we_i,
                        input int ack_at,
                        input logic [31:0] rdata);
    bit flt;
    bit acked;
    int stalls;
    int req_cycles;
    int req_hi;
    valid_in                 = 1'b1;
    mem_read_in              = rd_i;
    mem_write_in             = wr_i;
    funct3_in                = f3;
    alu_result_in            = addr;
    store_data_in            = sd;
    instruction_rd_in        = rdx;
    register_write_enable_in = we_i;
    mem_rdata                = rdata;
    @(negedge clk);
    flt = m_fault(rd_i, wr_i, f3, addr);
    if (!rd_i && !wr_i) begin
      chk("pt_wb", wb_data_out, addr);
      chk("pt_rd", 32'(instruction_rd_out), 32'(rdx));
      chk("pt_we", 32'(register_write_enable_out), 32'(we_i));
      chk("pt_stall", 32'(stall), 32'd0);
      chk("pt_req", 32'(mem_req), 32'd0);
      chk("pt_fault", 32'(mem_fault), 32'd0);
    end else if (flt) begin
      chk("flt_pulse", 32'(mem_fault), 32'd1);
      chk("flt_we", 32'(register_write_enable_out), 32'd0);
      chk("flt_stall", 32'(stall), 32'd0);
      chk("flt_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;
      chk("flt_noreq", 32'(mem_req), 32'd0);
      idle_inputs();
      return;
    end else begin
      chk("idle_fault", 32'(mem_fault), 32'd0);
      stalls = int'(stall);
      req_cycles = 0;
      req_hi = 0;
      acked = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < TIMEOUT; k++) begin
        mem_ack = (k == ack_at);
        @(negedge clk);
        stalls += int'(stall);
        req_hi += int'(mem_req);
        req_cycles++;
        if (k == 0) begin
          last_addr  = mem_addr;
          last_wdata = mem_wdata;
          last_wstrb = mem_wstrb;
          last_we    = mem_we;
          chk("bus_addr", mem_addr, {addr[31:2], 2'b00});
          chk("bus_we", 32'(mem_we), 32'(wr_i));
          chk("bus_wstrb", 32'(mem_wstrb),
              wr_i ? 32'(m_wstrb(f3, addr)) : 32'd0);
          if (wr_i) chk("bus_wdata", mem_wdata, m_wdata(f3, sd));
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        if (k == ack_at) begin
          acked = 1'b1;
          break;
        end
      end
      @(negedge clk);
      last_resp_fault = mem_fault;
      last_req_hi = req_hi;
      last_stalls = stalls;
      chk("resp_stall", 32'(stall), 32'd0);
      chk("resp_req", 32'(mem_req), 32'd0);
      chk("resp_fault", 32'(mem_fault), 32'(!acked));
      chk("resp_we", 32'(register_write_enable_out),
          32'(acked && rd_i && we_i));
      chk("resp_rd", 32'(instruction_rd_out), 32'(rdx));
      chk("stall_cycles", stalls, req_cycles + 1);
      chk("req_cycles", req_hi, req_cycles);
      if (acked && rd_i) begin
        last_wb = wb_data_out;
        chk("resp_load", wb_data_out, m_load(f3, addr, rdata));
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          sel;
    int          ack_at;
    rst = 1'b0;
    idle_inputs();
    funct3_in = 3'b000;
    alu_result_in = 32'h0;
    store_data_in = 32'h0;
    instruction_rd_in = 5'd0;
    register_write_enable_in = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // invalid slot never writes back
    register_write_enable_in = 1'b1;
    instruction_rd_in = 5'd9;
    @(negedge clk);
    chk("inv_we", 32'(register_write_enable_out), 32'd0);
    @(posedge clk);
    #1;

    mem_op(1, 0, 3'b000, 32'h1003, 32'h0, 5'd5, 1, 0, 32'h80FFFFFF);
    chk("lb_wb", last_wb, 32'hFFFFFF80);
    chk("lb_stall2", last_stalls, 2);

    mem_op(1, 0, 3'b101, 32'h2002, 32'h0, 5'd6, 1, 1, 32'hBEEF1234);
    chk("lhu_wb", last_wb, 32'h0000BEEF);

    mem_op(1, 0, 3'b010, 32'h2001, 32'h0, 5'd6, 1, 0, 32'h0);

    mem_op(0, 1, 3'b000, 32'h11, 32'h123456AB, 5'd3, 0, 0, 32'h0);
    chk("sb_addr", last_addr, 32'h10);
    chk("sb_wdata", last_wdata, 32'hABABABAB);
    chk("sb_wstrb", 32'(last_wstrb), 32'b0010);
    chk("sb_we", 32'(last_we), 32'd1);

    mem_op(0, 1, 3'b001, 32'h12, 32'h123456AB, 5'd3, 0, 2, 32'h0);
    chk("sh_wstrb", 32'(last_wstrb), 32'b1100);
    chk("sh_wdata", last_wdata, 32'h56AB56AB);

    mem_op(0, 0, 3'b000, 32'hDEADBEEF, 32'h0, 5'd7, 1, 0, 32'h0);

    mem_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd8, 1, -1, 32'h0);
    chk("to_fault", 32'(last_resp_fault), 32'd1);
    chk("to_req16", last_req_hi, 16);
    chk("to_stall17", last_stalls, 17);

    mem_op(1, 0, 3'b010, 32'h104, 32'h0, 5'd8, 1, 15, 32'hCAFEF00D);
    chk("late_ack_fault", 32'(last_resp_fault), 32'd0);
    chk("late_ack_wb", last_wb, 32'hCAFEF00D);

    mem_op(1, 1, 3'b010, 32'h200, 32'h0, 5'd1, 1, 0, 32'h0);
    mem_op(1, 0, 3'b011, 32'h200, 32'h0, 5'd1, 1, 0, 32'h0);

    // reset while a request is outstanding
    valid_in = 1'b1;
    mem_read_in = 1'b1;
    funct3_in = 3'b010;
    alu_result_in = 32'h40;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rq_req", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    chk("rq_rst_req", 32'(mem_req), 32'd0);
    chk("rq_rst_addr", mem_addr, 32'h0);
    chk("rq_rst_we", 32'(mem_we), 32'd0);
    chk("rq_rst_wstrb", 32'(mem_wstrb), 32'd0);
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h55555555;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_req", 32'(mem_req), 32'd0);
    chk("stray_stall", 32'(stall), 32'd0);
    chk("stray_fault", 32'(mem_fault), 32'd0);
    @(posedge clk);
    #1;
    mem_op(1, 0, 3'b100, 32'h43, 32'h0, 5'd2, 1, 0, 32'h9A000000);
    chk("post_rst_lbu", last_wb, 32'h0000009A);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                       : (sel[0] ? 3'($urandom_range(0, 2))
                                                 : 3'($urandom_range(4, 5)));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      ack_at = int'($urandom_range(0, TIMEOUT)) - 1;
      if (ack_at < 0 && $urandom_range(0, 2) != 0) ack_at = 0;
      mem_op(sel inside {1, 2, 3, 7}, sel inside {4, 5, 7},
             f3, a, $urandom, 5'($urandom), 1'($urandom),
             ack_at, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
